// File: rtl/ddram_bram_responder.sv
// ============================================================================
// Module  : ddram_bram_responder
// Purpose : Block-RAM backed responder for the 64-bit burst DDRAM master port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ddram_bram_responder #(
  parameter int ADDR_W    = 12,
  parameter int READ_LAT  = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        DDRAM_CLK,
  input  logic        RESET,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  input  logic        DDRAM_RD,
  input  logic        DDRAM_WE,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  output logic        PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_BURST  = 2'd1,
    RD_WAIT   = 2'd2,
    RD_STREAM = 2'd3
  } state_t;

  localparam int c_depth = 2 ** ADDR_W;

  logic [63:0]       r_mem [0:c_depth-1];
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_left;
  logic [2:0]        r_wait;
  logic              r_busy;
  logic              r_ready;
  logic [63:0]       r_dout;
  logic              r_proto_err;

  logic [ADDR_W-1:0] w_a;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_n;
  logic              w_wr_en;
  logic [63:0]       w_rd_data;
  logic              w_unused_addr_hi;

  assign w_a              = DDRAM_ADDR[ADDR_W-1:0];
  assign w_unused_addr_hi = ^DDRAM_ADDR[28:ADDR_W];
  assign w_n              = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
  // The first beat of any command takes its address straight from the port.
  assign w_addr           = (r_state == IDLE) ? w_a : r_addr;
  assign w_wr_en          = DDRAM_WE && !RESET &&
                            ((r_state == IDLE) || (r_state == WR_BURST));
  assign w_rd_data        = r_mem[w_addr];

  assign DDRAM_BUSY       = r_busy;
  assign DDRAM_DOUT_READY = r_ready;
  assign DDRAM_DOUT       = r_dout;
  assign PROTO_ERR        = r_proto_err;

  // Memory has no reset so contents survive RESET.
  always_ff @(posedge DDRAM_CLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (DDRAM_BE[i]) r_mem[w_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
      end
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_left      <= 8'd0;
      r_wait      <= 3'd0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_dout      <= 64'd0;
      r_proto_err <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (DDRAM_WE) begin
            r_addr <= w_a + 1'b1;
            r_left <= w_n - 8'd1;
            if (DDRAM_RD) r_proto_err <= 1'b1;
            if (w_n > 8'd1) r_state <= WR_BURST;
          end else if (DDRAM_RD) begin
            r_busy <= 1'b1;
            if (READ_LAT == 1) begin
              r_dout  <= w_rd_data;
              r_ready <= 1'b1;
              r_addr  <= w_a + 1'b1;
              r_left  <= w_n - 8'd1;
              r_state <= RD_STREAM;
            end else begin
              r_addr  <= w_a;
              r_left  <= w_n;
              r_wait  <= 3'(READ_LAT - 2);
              r_state <= RD_WAIT;
            end
          end
        end
        WR_BURST: begin
          if (DDRAM_RD) r_proto_err <= 1'b1;
          if (DDRAM_WE) begin
            r_addr <= r_addr + 1'b1;
            r_left <= r_left - 8'd1;
            if (r_left == 8'd1) r_state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (r_wait == 3'd0) begin
            r_dout  <= w_rd_data;
            r_ready <= 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_left  <= r_left - 8'd1;
            r_state <= RD_STREAM;
          end else begin
            r_wait <= r_wait - 3'd1;
          end
        end
        RD_STREAM: begin
          // BUSY stays high through the last strobe cycle, then drops.
          if (r_left != 8'd0) begin
            r_dout  <= w_rd_data;
            r_ready <= 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_left  <= r_left - 8'd1;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ddram_bram_responder.sv
// ============================================================================
// Module  : tb_ddram_bram_responder
// Purpose : Scoreboard bench for ddram_bram_responder (ADDR_W=12, READ_LAT=2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ddram_bram_responder;

  logic        clk_100 = 1'b0;
  logic        rst;
  logic        busy;
  logic [7:0]  bcnt;
  logic [28:0] addr;
  logic        rd;
  logic        we;
  logic [63:0] din;
  logic [7:0]  be;
  logic [63:0] dout;
  logic        rdy;
  logic        perr;

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          n_strobe = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  always #5 clk_100 = ~clk_100;

  ddram_bram_responder #(.ADDR_W(12), .READ_LAT(2), .INIT_FILE("")) dut (
    .DDRAM_CLK       (clk_100),
    .RESET           (rst),
    .DDRAM_BUSY      (busy),
    .DDRAM_BURSTCNT  (bcnt),
    .DDRAM_ADDR      (addr),
    .DDRAM_RD        (rd),
    .DDRAM_WE        (we),
    .DDRAM_DIN       (din),
    .DDRAM_BE        (be),
    .DDRAM_DOUT      (dout),
    .DDRAM_DOUT_READY(rdy),
    .PROTO_ERR       (perr)
  );

  // Scoreboard: every returned word must match the oldest expected word.
  always @(negedge clk_100) begin
    if (!rst && rdy) begin
      n_strobe++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: dout=%h, required no strobe", dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (dout !== mon_exp) begin
          n_err++;
          $display("FAIL read_data: got %h, required %h", dout, mon_exp);
        end
      end
    end
  end

  task automatic wr(input logic [28:0] a, input logic [7:0] n,
                    input logic [63:0] d, input logic [7:0] b);
    we = 1'b1; addr = a; bcnt = n; din = d; be = b;
    @(posedge clk_100); #1;
    we = 1'b0;
  endtask

  task automatic rd_cmd(input logic [28:0] a, input logic [7:0] n);
    rd = 1'b1; addr = a; bcnt = n;
    @(posedge clk_100); #1;
    rd = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk_100); #1;
      if (exp_q.size() == 0 && !busy) break;
    end
    if (k == 200) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: %0d words outstanding, busy=%b, required 0/0",
               name, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_100);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rd = 1'b0; we = 1'b0; bcnt = 8'd0; addr = '0; din = '0; be = '0;
    do_reset();
    @(negedge clk_100);
    n_cmp += 4;
    if (busy !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (rdy !== 1'b0)   begin n_err++; $display("FAIL rst_ready: got %b, required 0", rdy); end
    if (dout !== 64'd0) begin n_err++; $display("FAIL rst_dout: got %h, required 0", dout); end
    if (perr !== 1'b0)  begin n_err++; $display("FAIL rst_perr: got %b, required 0", perr); end
  endtask

  task automatic test_single();
    logic [1:0] b_seen, r_seen;
    @(posedge clk_100); #1;
    wr(29'h10, 8'd1, 64'h1122334455667788, 8'hFF);
    exp_q.push_back(64'h1122334455667788);
    rd_cmd(29'h10, 8'd1);              // accepted at edge ending cycle T
    @(negedge clk_100); b_seen[0] = busy; r_seen[0] = rdy;   // T+1
    @(negedge clk_100); b_seen[1] = busy; r_seen[1] = rdy;   // T+2
    n_cmp += 2;
    if (b_seen !== 2'b11) begin n_err++; $display("FAIL single_busy: got %b, required 11", b_seen); end
    if (r_seen !== 2'b10) begin n_err++; $display("FAIL single_ready: got %b, required 10", r_seen); end
    @(negedge clk_100);                                      // T+3
    n_cmp++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin
      n_err++; $display("FAIL single_release: busy=%b ready=%b, required 0/0", busy, rdy);
    end
    drain("single");
  endtask

  task automatic test_burst_stall();
    logic bw = 1'b0;
    int   run, k;
    wr(29'h20, 8'd4, 64'd1, 8'hFF); bw |= busy;
    wr(29'h0,  8'd0, 64'd2, 8'hFF); bw |= busy;
    repeat (2) begin @(posedge clk_100); #1; bw |= busy; end
    wr(29'h0,  8'd0, 64'd3, 8'hFF); bw |= busy;
    wr(29'h0,  8'd0, 64'd4, 8'hFF); bw |= busy;
    n_cmp++;
    if (bw !== 1'b0) begin n_err++; $display("FAIL burst_busy_during_write: got %b, required 0", bw); end
    for (int i = 1; i <= 4; i++) exp_q.push_back(64'(i));
    rd_cmd(29'h20, 8'd4);
    for (k = 0; k < 20; k++) begin @(negedge clk_100); if (rdy) break; end
    run = 0;
    while (rdy === 1'b1 && run < 12) begin run++; @(negedge clk_100); end
    n_cmp++;
    if (run != 4) begin n_err++; $display("FAIL burst_strobe_run: got %0d, required 4", run); end
    drain("burst");
  endtask

  task automatic test_byte_lane();
    wr(29'h5, 8'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    wr(29'h5, 8'd1, 64'h0, 8'h0F);
    wr(29'h6, 8'd1, 64'hA5A5A5A5A5A5A5A5, 8'hFF);
    wr(29'h6, 8'd0, 64'h0, 8'h00);     // BE=0 beat, count 0 treated as 1
    exp_q.push_back(64'hFFFFFFFF00000000);
    exp_q.push_back(64'hA5A5A5A5A5A5A5A5);
    rd_cmd(29'h5, 8'd2);
    drain("byte_lane");
  endtask

  task automatic test_wrap();
    logic [63:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 64'hC0FFEE0000000000 | 64'(i);
    wr(29'hFFE, 8'd4, w[0], 8'hFF);
    for (int i = 1; i < 4; i++) wr(29'h0, 8'd0, w[i], 8'hFF);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
    rd_cmd(29'h1000_0FFE, 8'd4);
    drain("wrap_alias");
    exp_q.push_back(w[2]); exp_q.push_back(w[3]);
    rd_cmd(29'h0, 8'd2);
    drain("wrap_low");
    exp_q.push_back(w[1]);
    rd_cmd(29'hFFF, 8'd1);
    drain("wrap_top");
  endtask

  task automatic test_proto_err();
    int base;
    base = n_strobe;
    rd = 1'b1;
    wr(29'h40, 8'd1, 64'h4040404040404040, 8'hFF);
    rd = 1'b0;
    wr(29'h50, 8'd2, 64'h5050505050505050, 8'hFF);
    rd = 1'b1;
    wr(29'h0, 8'd0, 64'h5151515151515151, 8'hFF);
    rd = 1'b0;
    repeat (6) @(negedge clk_100);
    n_cmp += 3;
    if (n_strobe != base) begin n_err++; $display("FAIL proto_no_strobe: got %0d, required 0", n_strobe - base); end
    if (perr !== 1'b1) begin n_err++; $display("FAIL proto_flag: got %b, required 1", perr); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL proto_busy: got %b, required 0", busy); end
    exp_q.push_back(64'h4040404040404040);
    @(posedge clk_100); #1;
    rd_cmd(29'h40, 8'd1);
    drain("proto_rdwe");
    exp_q.push_back(64'h5050505050505050);
    exp_q.push_back(64'h5151515151515151);
    rd_cmd(29'h50, 8'd2);
    drain("proto_burst");
    n_cmp++;
    if (perr !== 1'b1) begin n_err++; $display("FAIL proto_sticky: got %b, required 1", perr); end
    do_reset();
    @(negedge clk_100);
    n_cmp++;
    if (perr !== 1'b0) begin n_err++; $display("FAIL proto_clear: got %b, required 0", perr); end
  endtask

  task automatic test_reset_abort();
    int k, base;
    wr(29'h80, 8'd8, 64'hD000000000000000, 8'hFF);
    for (int i = 1; i < 8; i++) wr(29'h0, 8'd0, 64'hD000000000000000 | 64'(i), 8'hFF);
    for (int i = 0; i < 8; i++) exp_q.push_back(64'hD000000000000000 | 64'(i));
    base = n_strobe;
    rd_cmd(29'h80, 8'd8);
    k = 0;
    for (int c = 0; c < 30 && k < 3; c++) begin
      @(negedge clk_100);
      if (rdy) k++;
    end
    #1 rst = 1'b1;
    @(posedge clk_100); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk_100);
    n_cmp++;
    if (busy !== 1'b0 || rdy !== 1'b0) begin
      n_err++; $display("FAIL abort_release: busy=%b ready=%b, required 0/0", busy, rdy);
    end
    repeat (10) @(negedge clk_100);
    n_cmp++;
    if (n_strobe - base != 3) begin n_err++; $display("FAIL abort_strobes: got %0d, required 3", n_strobe - base); end
    for (int i = 0; i < 8; i++) exp_q.push_back(64'hD000000000000000 | 64'(i));
    @(posedge clk_100); #1;
    rd_cmd(29'h80, 8'd8);
    drain("abort_reread");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_burst_stall();
    test_byte_lane();
    test_wrap();
    test_proto_err();
    test_reset_abort();
    repeat (3) @(negedge clk_100);
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_expected: got %0d, required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
